// File: rtl/noc_output_arbiter.sv
// Output-port arbiter for a wormhole router: round-robin per packet, owns the
// downstream credit counter and the registered flit driving the output link.
module noc_output_arbiter #(
  parameter int NUM_IN  = 4,
  parameter int WIDTH   = 16,
  parameter int CREDITS = 5,
  parameter int CW      = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN-1:0]       req_i,
  input  logic [NUM_IN-1:0]       last_i,
  input  logic [NUM_IN*WIDTH-1:0] data_i,
  input  logic                    inc_credit_i,
  output logic [NUM_IN-1:0]       grant_o,
  output logic [WIDTH-1:0]        data_o,
  output logic                    send_data,
  output logic [CW-1:0]           credits_o,
  output logic                    busy_o,
  output logic                    credit_err_o
);

  localparam int IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t           state;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    owner;
  logic [CW-1:0]    credits;

  logic [IW-1:0]    cand;
  logic [IW-1:0]    win_idx;
  logic             win_found;
  logic [IW-1:0]    sel_idx;
  logic             sel_valid;
  logic             sel_last;
  logic [WIDTH-1:0] sel_data;
  logic [IW-1:0]    nxt_ptr;
  logic             can_send;
  logic             grant_any;

  // Circular search starting at rr_ptr; first hit wins.
  always_comb begin
    cand      = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      cand = IW'((32'(rr_ptr) + k) % NUM_IN);
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // A locked packet only ever considers its owner.
  always_comb begin
    can_send  = (credits != '0);
    sel_idx   = (state == LOCKED) ? owner : win_idx;
    sel_valid = (state == LOCKED) ? req_i[owner] : win_found;
    grant_any = !rst && can_send && sel_valid;
    sel_last  = last_i[sel_idx];
    sel_data  = data_i[32'(sel_idx)*WIDTH +: WIDTH];
    nxt_ptr   = IW'((32'(sel_idx) + 1) % NUM_IN);
    grant_o   = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      grant_o[i] = grant_any && (sel_idx == IW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      credits      <= CW'(CREDITS);
      data_o       <= '0;
      send_data    <= 1'b0;
      credit_err_o <= 1'b0;
    end else begin
      send_data <= grant_any;
      if (grant_any) begin
        data_o <= sel_data;
        if (sel_last) begin
          state  <= IDLE;
          rr_ptr <= nxt_ptr;
        end else begin
          state <= LOCKED;
          owner <= sel_idx;
        end
      end
      // Simultaneous send and return cancel; a return at full count is an overflow.
      case ({grant_any, inc_credit_i})
        2'b10: credits <= credits - CW'(1);
        2'b01: begin
          if (credits == CW'(CREDITS)) begin
            credit_err_o <= 1'b1;
          end else begin
            credits <= credits + CW'(1);
          end
        end
        default: credits <= credits;
      endcase
    end
  end

  assign credits_o = credits;
  assign busy_o    = (state == LOCKED);

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Self-checking bench for noc_output_arbiter: per-cycle reference model plus
// directed scenarios with literal expectations.
module tb_noc_output_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int CR = 5;
  localparam int CW = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    last = '0;
  logic [N*W-1:0]  data = '0;
  logic            inc = 1'b0;
  logic [N-1:0]    grant_o;
  logic [W-1:0]    data_o;
  logic            send_data;
  logic [CW-1:0]   credits_o;
  logic            busy_o;
  logic            credit_err_o;

  int total = 0;
  int bad   = 0;

  noc_output_arbiter #(.NUM_IN(N), .WIDTH(W), .CREDITS(CR), .CW(CW)) dut (
    .clk(clk), .rst(rst), .req_i(req), .last_i(last), .data_i(data),
    .inc_credit_i(inc), .grant_o(grant_o), .data_o(data_o), .send_data(send_data),
    .credits_o(credits_o), .busy_o(busy_o), .credit_err_o(credit_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: packet-level view of who may send and what credit is left.
  bit        m_valid = 0;
  bit        m_locked;
  int        m_owner, m_ptr, m_cred;
  bit        m_err, m_send;
  logic [W-1:0] m_data;

  function automatic int pick(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    int w;
    logic [N-1:0] eg;
    w = -1;
    if (!rst && m_valid && m_cred > 0) begin
      if (m_locked) w = req[m_owner] ? m_owner : -1;
      else          w = pick(req, m_ptr);
    end
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    if (rst || m_valid) check("grant", int'(grant_o), int'(eg));
    if (m_valid) begin
      check("send_data", int'(send_data), int'(m_send));
      if (m_send) check("data_o", int'(data_o), int'(m_data));
      check("credits", int'(credits_o), m_cred);
      check("busy", int'(busy_o), int'(m_locked));
      check("credit_err", int'(credit_err_o), int'(m_err));
      check("no_grant_at_zero", int'(credits_o == 0 && grant_o != 0), 0);
    end
    if (rst) begin
      m_valid = 1; m_locked = 0; m_owner = 0; m_ptr = 0; m_cred = CR;
      m_err = 0; m_send = 0; m_data = '0;
    end else if (m_valid) begin
      m_send = (w >= 0);
      if (w >= 0) begin
        m_data = data[w*W +: W];
        if (last[w]) begin m_locked = 0; m_ptr = (w + 1) % N; end
        else begin m_locked = 1; m_owner = w; end
      end
      if (w >= 0 && !inc) m_cred--;
      else if (w < 0 && inc) begin
        if (m_cred == CR) m_err = 1; else m_cred++;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; req = '0; last = '0; inc = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_flit(input int i, input logic [W-1:0] v);
    data[i*W +: W] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
    @(negedge clk);
    check("L reset credits", int'(credits_o), 5);
    check("L reset busy", int'(busy_o), 0);
    check("L reset send", int'(send_data), 0);
    check("L reset data", int'(data_o), 0);
    check("L reset err", int'(credit_err_o), 0);
    tick();

    // 1: three-flit packet on input 0
    req = 4'b0001; last = 4'b0000; set_flit(0, 16'hA001);
    @(negedge clk); check("L t1 g0", int'(grant_o), 1); tick();
    set_flit(0, 16'hA002);
    @(negedge clk); check("L t1 g1", int'(grant_o), 1);
    check("L t1 d1", int'(data_o), 16'hA001); check("L t1 busy", int'(busy_o), 1); tick();
    set_flit(0, 16'hA003); last = 4'b0001;
    @(negedge clk); check("L t1 g2", int'(grant_o), 1);
    check("L t1 d2", int'(data_o), 16'hA002); check("L t1 c2", int'(credits_o), 3); tick();
    req = '0; last = '0;
    @(negedge clk); check("L t1 d3", int'(data_o), 16'hA003); check("L t1 s3", int'(send_data), 1);
    check("L t1 cred", int'(credits_o), 2); check("L t1 idle", int'(busy_o), 0); tick();

    // 2: four single-flit requesters with a credit returned every cycle
    do_reset();
    req = 4'b1111; last = 4'b1111; inc = 1'b1;
    for (int i = 0; i < N; i++) set_flit(i, 16'hB000 + 16'(i));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("L t2 grant", int'(grant_o), 1 << (c % 4));
      check("L t2 cred", int'(credits_o), 5);
      tick();
    end
    req = '0; last = '0; inc = 1'b0;
    @(negedge clk); check("L t2 cred end", int'(credits_o), 5); tick();

    // 3: input 1 holds the port until its tail, then input 2 follows
    do_reset();
    set_flit(1, 16'hC100); set_flit(2, 16'hC200);
    req = 4'b0010; last = 4'b0000;
    @(negedge clk); check("L t3 head", int'(grant_o), 4'b0010); tick();
    req = 4'b0110; last = 4'b0100;
    @(negedge clk); check("L t3 body", int'(grant_o), 4'b0010); tick();
    req = 4'b0100;
    @(negedge clk); check("L t3 bubble", int'(grant_o), 0); check("L t3 busy", int'(busy_o), 1); tick();
    req = 4'b0110; last = 4'b0110;
    @(negedge clk); check("L t3 tail", int'(grant_o), 4'b0010); tick();
    req = 4'b0100; last = 4'b0100;
    @(negedge clk); check("L t3 next", int'(grant_o), 4'b0100); tick();
    req = '0; last = '0;
    @(negedge clk); check("L t3 cred", int'(credits_o), 1); tick();

    // 4: credit exhaustion on a long packet
    do_reset();
    req = 4'b0001; last = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      set_flit(0, 16'hD000 + 16'(k));
      @(negedge clk);
      check("L t4 grant", int'(grant_o), 1);
      check("L t4 cred", int'(credits_o), 5 - k);
      tick();
    end
    set_flit(0, 16'hD005);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); check("L t4 stall", int'(grant_o), 0); check("L t4 zero", int'(credits_o), 0); tick();
    end
    inc = 1'b1;
    @(negedge clk); check("L t4 inc no grant", int'(grant_o), 0); tick();
    inc = 1'b0;
    @(negedge clk); check("L t4 one cred", int'(credits_o), 1); check("L t4 regrant", int'(grant_o), 1); tick();
    set_flit(0, 16'hD006);
    @(negedge clk); check("L t4 stall2", int'(grant_o), 0); check("L t4 data", int'(data_o), 16'hD005); tick();

    // 5: send and return in one cycle; overflow at full count
    do_reset();
    req = 4'b0001; last = 4'b0001; set_flit(0, 16'hE000);
    tick(); tick();
    inc = 1'b1;
    @(negedge clk); check("L t5 c3", int'(credits_o), 3); check("L t5 g", int'(grant_o), 1); tick();
    req = '0; last = '0; inc = 1'b0;
    @(negedge clk); check("L t5 hold3", int'(credits_o), 3); tick();
    do_reset();
    inc = 1'b1;
    @(negedge clk); check("L t5 err pre", int'(credit_err_o), 0); tick();
    inc = 1'b0;
    @(negedge clk); check("L t5 sat", int'(credits_o), 5); check("L t5 err", int'(credit_err_o), 1); tick();
    @(negedge clk); check("L t5 sticky", int'(credit_err_o), 1); tick();
    do_reset();
    @(negedge clk); check("L t5 err clr", int'(credit_err_o), 0); tick();

    // 6: reset abandons a locked packet
    req = 4'b1000; last = 4'b0000; set_flit(3, 16'hF300); set_flit(0, 16'hF000);
    tick(); tick(); tick(); tick();
    req = '0;
    @(negedge clk); check("L t6 c1", int'(credits_o), 1); check("L t6 locked", int'(busy_o), 1); tick();
    req = 4'b1000; rst = 1'b1;
    @(negedge clk); check("L t6 rst grant", int'(grant_o), 0); tick();
    rst = 1'b0; req = '0;
    @(negedge clk); check("L t6 busy", int'(busy_o), 0); check("L t6 cred", int'(credits_o), 5);
    check("L t6 send", int'(send_data), 0); tick();
    req = 4'b1001; last = 4'b1001;
    @(negedge clk); check("L t6 first", int'(grant_o), 4'b0001); tick();
    @(negedge clk); check("L t6 second", int'(grant_o), 4'b1000); tick();
    req = '0; last = '0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
